sram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller built around the 48x32 1W1R OpenRAM macro (freepdk45_sram_1w1r_48x32_32). It accepts a valid/ready stream, writes words through SRAM port 0 and reads them back through port 1. Read data lands in a 2-entry output buffer, so the output stream sustains one word per cycle. Both SRAM clocks (clk0, clk1) are tied to this block's clk0 at the parent.

---
 rtl/sram_fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// Stream FIFO controller around a 1W1R SRAM macro with a 2-entry output buffer.
// Optional SRAM_FIFO_STATS_EN adds max_count (high-water mark) and stall_cnt.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 48
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [6:0]            count,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SRAM_FIFO_STATS_EN
  ,
  output logic [6:0]            max_count,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [6:0]            DEPTH_C  = 7'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]            sram_cnt_q, sram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic push, pop, rd_go, buf_room;

  assign in_ready  = !rst && (sram_cnt_q < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = buf0_q;
  assign count     = sram_cnt_q + 7'(inflight_q) + 7'(buf_cnt_q);

  // A read may issue only if the buffer can absorb it, counting the word already in flight.
  assign buf_room  = (buf_cnt_q == 2'd0) || (buf_cnt_q == 2'd1 && !inflight_q);
  assign rd_go     = !rst && (sram_cnt_q != 7'd0) && (buf_room || pop);

  assign sram_csb0  = !push;
  assign sram_addr0 = wr_ptr_q;
  assign sram_din0  = in_data;
  assign sram_csb1  = !rd_go;
  assign sram_addr1 = rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (rd_go) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    sram_cnt_d = sram_cnt_q + 7'(push) - 7'(rd_go);
    inflight_d = rd_go;

    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = sram_dout1;
        else                   buf1_d = sram_dout1;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = sram_dout1;
        end else begin
          buf0_d = buf1_q;
          buf1_d = sram_dout1;
        end
      end
      default: ;
    endcase
  end

`ifdef SRAM_FIFO_STATS_EN
  logic [6:0]  max_count_q, max_count_d, count_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    count_d     = sram_cnt_d + 7'(inflight_d) + 7'(buf_cnt_d);
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      max_count_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      max_count_q <= max_count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign max_count = max_count_q;
  assign stall_cnt = stall_cnt_q;
`endif

  // Reset drops any read in flight; buffer data words need no reset.
  always_ff @(posedge clk0) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized self-checking bench for sram_fifo_ctrl with a behavioural SRAM and a queue model.
module tb_sram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 48;

  logic          clk0 = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [6:0]    count;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout1 = '0;
`ifdef SRAM_FIFO_STATS_EN
  logic [6:0]    max_count;
  logic [15:0]   stall_cnt;
`endif

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk0(clk0), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
`ifdef SRAM_FIFO_STATS_EN
    , .max_count(max_count), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk0 = ~clk0;

  // SRAM model: ports latched before the edge, read data valid from the following negedge only.
  logic [DW-1:0] mem [0:63];
  logic          p_wr = 1'b0, p_rd = 1'b0, rd_pend = 1'b0;
  logic [AW-1:0] p_a0 = '0, p_a1 = '0;
  logic [DW-1:0] p_d0 = '0, rd_val = '0;
  always begin
    @(posedge clk0);
    rd_pend = p_rd;
    if (p_rd) rd_val = mem[p_a1];
    if (p_wr) mem[p_a0] = p_d0;
    #1 sram_dout1 = 32'hDEAD_BEEF;
    @(negedge clk0);
    if (rd_pend) sram_dout1 = rd_val;
    p_wr = !sram_csb0; p_a0 = sram_addr0; p_d0 = sram_din0;
    p_rd = !sram_csb1; p_a1 = sram_addr1;
  end

  int n_checks = 0, n_pass = 0;
  logic [DW-1:0] model_q [$];
  int wr_n = 0, rd_n = 0, wr_wraps = 0, rd_wraps = 0;
  int n_push = 0, n_pop = 0;
  logic s_in_ready, s_out_valid;
  logic [6:0] s_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle: drive inputs, sample at the negedge, update the reference model.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy);
    logic [DW-1:0] exp_d;
    in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk0);
    s_in_ready = in_ready; s_out_valid = out_valid; s_count = count;
    chk("count", 32'(count), 32'(model_q.size()));
    chk("csb0", 32'(sram_csb0), 32'(!(iv && in_ready)));
    if (!sram_csb0) begin
      chk("wr_addr", 32'(sram_addr0), 32'(wr_n % DEPTH));
      chk("wr_data", sram_din0, d);
      if (wr_n > 0 && wr_n % DEPTH == 0) wr_wraps++;
      wr_n++;
    end
    if (!sram_csb1) begin
      chk("rd_addr", 32'(sram_addr1), 32'(rd_n % DEPTH));
      if (rd_n > 0 && rd_n % DEPTH == 0) rd_wraps++;
      rd_n++;
    end
    if (!sram_csb0 && !sram_csb1) chk("addr_collide", 32'(sram_addr0 != sram_addr1), 32'd1);
    if (out_valid && ordy) begin
      chk("pop_avail", 32'(model_q.size() > 0), 32'd1);
      if (model_q.size() > 0) begin
        exp_d = model_q.pop_front();
        chk("out_data", out_data, exp_d);
      end
      n_pop++;
    end
    if (iv && in_ready) begin
      model_q.push_back(d);
      n_push++;
    end
    @(posedge clk0); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk0); #1;
    @(negedge clk0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_csb1", 32'(sram_csb1), 32'd1);
    @(posedge clk0); #1;
    rst = 1'b0;
    model_q.delete();
    wr_n = 0; rd_n = 0;
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    while (model_q.size() > 0 && k < max_cycles) begin
      cycle(1'b0, '0, 1'b1);
      k++;
    end
    chk("drain_done", 32'(model_q.size()), 32'd0);
    cycle(1'b0, '0, 1'b1);
    chk("drain_count", 32'(s_count), 32'd0);
  endtask

  initial begin
    int first_k, bubbles, stalls, cyc;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0);
      chk("idle_in_ready", 32'(s_in_ready), 32'd1);
      chk("idle_out_valid", 32'(s_out_valid), 32'd0);
    end

    // Single word latency
    cycle(1'b1, 32'hA5A5_0001, 1'b1);
    first_k = -1;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, '0, 1'b1);
      if (s_out_valid && first_k < 0) first_k = k;
    end
    chk("latency", 32'(first_k), 32'd3);
    chk("single_count", 32'(s_count), 32'd0);

    // Fill to capacity with output stalled
    n_push = 0; n_pop = 0;
    for (int i = 0; i < 60; i++) cycle(1'b1, 32'(i), 1'b0);
    chk("fill_accepted", 32'(n_push), 32'd50);
    cycle(1'b0, '0, 1'b0);
    chk("full_count", 32'(s_count), 32'd50);
    chk("full_in_ready", 32'(s_in_ready), 32'd0);
`ifdef SRAM_FIFO_STATS_EN
    chk("max_count", 32'(max_count), 32'd50);
    chk("stall_cnt", 32'(stall_cnt), 32'd10);
`endif
    drain(80);
    chk("fill_popped", 32'(n_pop), 32'd50);

    // Full-rate streaming
    n_push = 0; n_pop = 0; wr_wraps = 0; rd_wraps = 0;
    first_k = -1; bubbles = 0; stalls = 0;
    for (int k = 0; k < 210; k++) begin
      cycle(n_push < 200, 32'h1000 + 32'(n_push), 1'b1);
      if (k < 200 && !s_in_ready) stalls++;
      if (s_out_valid && first_k < 0) first_k = k;
      if (first_k >= 0 && !s_out_valid && n_pop < 200) bubbles++;
    end
    chk("stream_pushes", 32'(n_push), 32'd200);
    chk("stream_pops", 32'(n_pop), 32'd200);
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_first", 32'(first_k), 32'd3);
    chk("wr_wraps", 32'(wr_wraps >= 4), 32'd1);
    chk("rd_wraps", 32'(rd_wraps >= 4), 32'd1);

    // Random traffic
    n_push = 0; n_pop = 0; cyc = 0;
    while (n_push < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_pushes", 32'(n_push), 32'd1000);
    drain(200);
    chk("rand_balance", 32'(n_pop), 32'd1000);

    // Reset with words held and a read in flight
    for (int i = 0; i < 22; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("pre_rst_count", 32'(s_count), 32'd22);
    do_reset();
    n_push = 0; n_pop = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b1);
    chk("post_rst_pushes", 32'(n_push), 32'd5);
    drain(20);
    chk("post_rst_pops", 32'(n_pop), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("post_rst_idle", 32'(s_out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
